// File: rtl/ecc_lockstep_chk.sv
// ecc_lockstep_chk: dual (lockstep) SECDED decode/correct with a 1-deep output
// register slice, a NORMAL/SUSPECT/LOCKED fault FSM and saturating event counters.
// Optional: define ECC_LOCKSTEP_ERR_INJ_EN to add inj_en/inj_bit, which flip one
// data bit at the secondary decoder input only.
//
// Code layout: Hamming positions 1..2^(PARITY_WIDTH-1)-1; data bits occupy the
// non-power-of-two positions in ascending order. parity[i] (i < PARITY_WIDTH-1)
// covers positions with bit i set. parity[PARITY_WIDTH-1] is the overall parity.

module ecc_lockstep_secded_dec #(
  parameter int unsigned DATA_WIDTH   = 155,
  parameter int unsigned PARITY_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [PARITY_WIDTH-1:0] parity,
  input  logic                    bypass,
  output logic                    sbit,
  output logic                    dbit,
  output logic [DATA_WIDTH-1:0]   mask
);
  localparam int unsigned SW = PARITY_WIDTH - 1;

  function automatic logic [DATA_WIDTH*SW-1:0] gen_pos();
    logic [DATA_WIDTH*SW-1:0] tbl;
    int unsigned p;
    tbl = '0;
    p   = 3;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      while ((p & (p - 1)) == 0) p++;
      tbl[k*SW +: SW] = SW'(p);
      p++;
    end
    return tbl;
  endfunction

  localparam logic [DATA_WIDTH*SW-1:0] POS_TBL = gen_pos();

  logic [SW-1:0] syn;
  logic          overall;

  // Syndrome is the stored check bits XORed with the positions of all set data bits
  always_comb begin
    syn     = parity[SW-1:0];
    overall = (^data) ^ (^parity);
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      if (data[k]) syn = syn ^ POS_TBL[k*SW +: SW];
    end
  end

  // Classify and build the correction mask; an error on a check bit yields no mask
  always_comb begin
    sbit = overall;
    dbit = ~overall & (syn != '0);
    mask = '0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      mask[k] = overall & ~bypass & (syn == POS_TBL[k*SW +: SW]);
    end
  end
endmodule

module ecc_lockstep_chk #(
  parameter int unsigned DATA_WIDTH   = 155,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned FAULT_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic                    ecc_fault,
  input  logic                    fault_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    miscmp_cnt
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
  ,
  input  logic                          inj_en,
  input  logic [$clog2(DATA_WIDTH)-1:0] inj_bit
`endif
);
  typedef enum logic [1:0] {NORMAL, SUSPECT, LOCKED} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]           THRESH  = 4'(FAULT_THRESH);

  state_e                  state_q, state_d;
  logic [3:0]              consec_q, consec_d, consec_inc;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    sbit_err_q, sbit_err_d, dbit_err_q, dbit_err_d;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]    miscmp_cnt_q, miscmp_cnt_d;

  logic [DATA_WIDTH-1:0]   data_sec;
  logic                    sbit_p, dbit_p, sbit_s, dbit_s;
  logic [DATA_WIDTH-1:0]   mask_p, mask_s;
  logic                    miscmp, acc;

  // Secondary decoder input, optionally with one injected bit flip
  always_comb begin
    data_sec = data_in;
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    if (inj_en) data_sec[inj_bit] = ~data_in[inj_bit];
`endif
  end

  ecc_lockstep_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_pri (
    .data(data_in), .parity(parity_in), .bypass(bypass),
    .sbit(sbit_p), .dbit(dbit_p), .mask(mask_p)
  );

  ecc_lockstep_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_sec (
    .data(data_sec), .parity(parity_in), .bypass(bypass),
    .sbit(sbit_s), .dbit(dbit_s), .mask(mask_s)
  );

  // Handshake and lockstep compare
  always_comb begin
    in_rdy     = ~out_vld_q | out_rdy;
    acc        = in_vld & in_rdy;
    miscmp     = ({sbit_p, dbit_p, mask_p} != {sbit_s, dbit_s, mask_s}) & ecc_fault_detc_en;
    consec_inc = consec_q + 4'd1;
  end

  // State register and all datapath/counter flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      consec_q     <= '0;
      out_vld_q    <= 1'b0;
      data_out_q   <= '0;
      sbit_err_q   <= 1'b0;
      dbit_err_q   <= 1'b0;
      sbit_cnt_q   <= '0;
      dbit_cnt_q   <= '0;
      miscmp_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      consec_q     <= consec_d;
      out_vld_q    <= out_vld_d;
      data_out_q   <= data_out_d;
      sbit_err_q   <= sbit_err_d;
      dbit_err_q   <= dbit_err_d;
      sbit_cnt_q   <= sbit_cnt_d;
      dbit_cnt_q   <= dbit_cnt_d;
      miscmp_cnt_q <= miscmp_cnt_d;
    end
  end

  // Next-state: fault_clr wins; otherwise step only on accepted, enabled transfers
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    if (fault_clr) begin
      state_d  = NORMAL;
      consec_d = '0;
    end else if (acc && ecc_fault_detc_en) begin
      case (state_q)
        NORMAL, SUSPECT: begin
          if (miscmp) begin
            consec_d = consec_inc;
            state_d  = (consec_inc >= THRESH) ? LOCKED : SUSPECT;
          end else begin
            consec_d = '0;
            state_d  = NORMAL;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    ecc_fault = (state_q == LOCKED);
  end

  // Output register slice: load on accept, drop valid once consumed
  always_comb begin
    out_vld_d  = out_vld_q;
    data_out_d = data_out_q;
    sbit_err_d = sbit_err_q;
    dbit_err_d = dbit_err_q;
    if (acc) begin
      out_vld_d  = 1'b1;
      data_out_d = (~miscmp && state_q != LOCKED) ? (data_in ^ mask_p) : data_in;
      sbit_err_d = sbit_p;
      dbit_err_d = dbit_p;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Saturating event counters; fault_clr discards the same-cycle events
  always_comb begin
    sbit_cnt_d   = sbit_cnt_q;
    dbit_cnt_d   = dbit_cnt_q;
    miscmp_cnt_d = miscmp_cnt_q;
    if (fault_clr) begin
      sbit_cnt_d   = '0;
      dbit_cnt_d   = '0;
      miscmp_cnt_d = '0;
    end else if (acc) begin
      if (sbit_p && sbit_cnt_q != CNT_MAX)   sbit_cnt_d   = sbit_cnt_q + 1'b1;
      if (dbit_p && dbit_cnt_q != CNT_MAX)   dbit_cnt_d   = dbit_cnt_q + 1'b1;
      if (miscmp && miscmp_cnt_q != CNT_MAX) miscmp_cnt_d = miscmp_cnt_q + 1'b1;
    end
  end

  // Port mapping
  always_comb begin
    out_vld    = out_vld_q;
    data_out   = data_out_q;
    sbit_err   = sbit_err_q;
    dbit_err   = dbit_err_q;
    sbit_cnt   = sbit_cnt_q;
    dbit_cnt   = dbit_cnt_q;
    miscmp_cnt = miscmp_cnt_q;
  end
endmodule
